// File: rtl/trng_postproc.sv
// TRNG post-processing: repetition-count health test, von Neumann corrector, word packer and output FIFO.
// Define TRNG_APT_EN to add the adaptive proportion test alongside the repetition-count test.
//
// state  | meaning
// IDLE   | stopped, no sampling; FIFO contents kept
// WARMUP | health test running, raw bits counted and discarded
// RUN    | health test and corrector running, words packed into the FIFO
// FAIL   | health failure latched, FIFO flushed, waits for fail_clear
module trng_postproc #(
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int WARMUP_BITS = 64,
  parameter int RCT_CUTOFF  = 16,
  parameter int APT_WINDOW  = 64,
  parameter int APT_CUTOFF  = 48
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [7:0]                    rand_in,
  input  logic                          fail_clear,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          health_fail,
  output logic                          overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int CNT_W  = $clog2(DATA_W);
  localparam int WARM_W = $clog2(WARMUP_BITS + 1);
  localparam int RCT_W  = $clog2(RCT_CUTOFF + 1);

  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(WARMUP_BITS);
  localparam logic [RCT_W-1:0]  RCT_LIM   = RCT_W'(RCT_CUTOFF);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_RUN,
    ST_FAIL
  } state_t;

  state_t state, state_nxt;

  logic raw;
  logic unused_rand;
  logic active;
  logic run_active;
  logic health_bad;
  logic rct_fail;
  logic apt_fail;

  assign raw         = rand_in[0];
  assign unused_rand = ^rand_in[7:1];

  // Sampling stops in the same cycle enable drops, so a leaving cycle never emits.
  assign active     = enable && ((state == ST_WARMUP) || (state == ST_RUN));
  assign health_bad = rct_fail || apt_fail;
  assign run_active = (state == ST_RUN) && active && !health_bad;

  // ---------------------------------------------------------------- warmup
  logic [WARM_W-1:0] warm_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      warm_cnt <= WARM_LOAD;
    end else if ((state == ST_WARMUP) && active) begin
      warm_cnt <= warm_cnt - 1'b1;
    end else begin
      warm_cnt <= WARM_LOAD;
    end
  end

  // ---------------------------------------------------------------- repetition count
  logic             rct_seen;
  logic             rct_prev;
  logic [RCT_W-1:0] rct_cnt;
  logic [RCT_W-1:0] rct_cnt_nxt;

  always_comb begin
    rct_cnt_nxt = RCT_W'(1);
    if (rct_seen && (raw == rct_prev)) begin
      rct_cnt_nxt = rct_cnt + 1'b1;
    end
  end

  assign rct_fail = active && (rct_cnt_nxt == RCT_LIM);

  always_ff @(posedge clk) begin
    if (reset || !active || health_bad) begin
      rct_seen <= 1'b0;
      rct_prev <= 1'b0;
      rct_cnt  <= '0;
    end else begin
      rct_seen <= 1'b1;
      rct_prev <= raw;
      rct_cnt  <= rct_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------- adaptive proportion
`ifdef TRNG_APT_EN
  localparam int APT_W = $clog2(APT_WINDOW + 1);
  localparam logic [APT_W-1:0] APT_LIM  = APT_W'(APT_CUTOFF);
  localparam logic [APT_W-1:0] APT_LAST = APT_W'(APT_WINDOW - 1);

  logic [APT_W-1:0] apt_left;
  logic [APT_W-1:0] apt_match;
  logic [APT_W-1:0] apt_match_nxt;
  logic             apt_ref;

  // apt_left == 0 means the next sample opens a new window as its reference.
  always_comb begin
    apt_match_nxt = APT_W'(1);
    if (apt_left != '0) begin
      apt_match_nxt = apt_match + APT_W'(raw == apt_ref);
    end
  end

  assign apt_fail = active && (apt_match_nxt > APT_LIM);

  always_ff @(posedge clk) begin
    if (reset || !active || health_bad) begin
      apt_left  <= '0;
      apt_match <= '0;
      apt_ref   <= 1'b0;
    end else if (apt_left == '0) begin
      apt_left  <= APT_LAST;
      apt_match <= APT_W'(1);
      apt_ref   <= raw;
    end else begin
      apt_left  <= apt_left - 1'b1;
      apt_match <= apt_match_nxt;
    end
  end
`else
  localparam int unused_apt = APT_WINDOW + APT_CUTOFF;
  assign apt_fail = 1'b0;
`endif

  // ---------------------------------------------------------------- state machine
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_WARMUP;
      end
      ST_WARMUP: begin
        if (!enable)                       state_nxt = ST_IDLE;
        else if (health_bad)               state_nxt = ST_FAIL;
        else if (warm_cnt == WARM_W'(1))   state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!enable)         state_nxt = ST_IDLE;
        else if (health_bad) state_nxt = ST_FAIL;
      end
      ST_FAIL: begin
        if (fail_clear) state_nxt = enable ? ST_WARMUP : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign health_fail = (state == ST_FAIL);

  // ---------------------------------------------------------------- corrector and packer
  logic              pair_have;
  logic              pair_first;
  logic [CNT_W-1:0]  pack_cnt;
  logic [DATA_W-1:0] pack_word;
  logic [DATA_W-1:0] pack_nxt;
  logic              emit;
  logic              push;

  // The emitted bit of a 01/10 pair is always its first bit.
  assign emit = run_active && pair_have && (pair_first != raw);
  assign push = emit && (pack_cnt == CNT_LAST);

  always_comb begin
    pack_nxt           = pack_word;
    pack_nxt[pack_cnt] = pair_first;
  end

  always_ff @(posedge clk) begin
    if (reset || !run_active) begin
      pair_have  <= 1'b0;
      pair_first <= 1'b0;
      pack_cnt   <= '0;
      pack_word  <= '0;
    end else if (!pair_have) begin
      pair_have  <= 1'b1;
      pair_first <= raw;
    end else begin
      pair_have <= 1'b0;
      if (push) begin
        pack_cnt  <= '0;
        pack_word <= '0;
      end else if (emit) begin
        pack_cnt  <= pack_cnt + 1'b1;
        pack_word <= pack_nxt;
      end
    end
  end

  // ---------------------------------------------------------------- output FIFO
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  fifo_cnt;
  logic              flush;
  logic              pop;
  logic              full;
  logic              wr_ok;
  logic              drop;

  assign flush = (state != ST_FAIL) && (state_nxt == ST_FAIL);
  assign pop   = out_valid && out_ready;
  assign full  = (fifo_cnt == FULL_LVL);
  // A simultaneous pop frees the slot before the push needs it.
  assign wr_ok = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !reset && !flush) begin
      fifo_mem[wr_ptr] <= pack_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  assign out_valid  = (fifo_cnt != '0);
  assign out_data   = out_valid ? fifo_mem[rd_ptr] : '0;
  assign fifo_level = fifo_cnt;

endmodule

// File: doc/trng_postproc.md
Name: trng_postproc

Overview:
- Consumer stage for the 8-bit TRNG generator output. Samples one fresh raw bit per cycle and runs a continuous repetition-count health test on the raw stream.
- Removes bias with a von Neumann corrector and packs corrected bits into DATA_W-bit words.
- Buffers the words in a small FIFO and presents them on a valid/ready interface to the system bus / key logic.

Parameters:
- DATA_W, 32, output word width in bits (8..64).
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2).
- WARMUP_BITS, 64, raw bits discarded after enable or after a fail clear (>=1).
- RCT_CUTOFF, 16, repetition-count limit: a run of this many identical raw bits is a failure (>=2).
- APT_WINDOW, 64, adaptive proportion window length in raw bits (used only with TRNG_APT_EN).
- APT_CUTOFF, 48, maximum count of the window's first bit inside one window (used only with TRNG_APT_EN).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request.
- rand_in  in  8  generator output; bit 0 is the newest bit each cycle.
- fail_clear  in  1  single-cycle pulse; leaves FAIL.
- out_data  out  DATA_W  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head word when out_valid & out_ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- health_fail  out  1  high while in FAIL.
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full.

Behaviour:
- Reset, synchronous, when reset=1 at a clk edge:
  - State goes to IDLE.
  - FIFO is emptied; all counters, the pair register and the packer are cleared.
  - Outputs: out_valid=0, out_data=0, fifo_level=0, health_fail=0, overflow=0.
  - Reset has priority over every other input, including in the middle of a word or in FAIL.
- Raw bit = rand_in[0], sampled every cycle while in WARMUP or RUN. No sampling in IDLE or FAIL.
- State machine:
  - IDLE: nothing is sampled. Goes to WARMUP when enable=1.
  - WARMUP: the health test is active; raw bits are counted and discarded. Goes to RUN after WARMUP_BITS samples.
  - RUN: the health test and the corrector are active.
  - Any state except FAIL: enable=0 -> IDLE. On this exit the pair register, packer bit count and health counters are cleared; FIFO contents are kept.
  - WARMUP or RUN: a health failure -> FAIL on the next edge.
  - FAIL: health_fail=1 and the FIFO is flushed on entry. out_valid stays 0 throughout FAIL. Nothing is sampled.
  - FAIL with fail_clear=1: goes to WARMUP if enable=1, otherwise IDLE. enable alone never exits FAIL.
- Repetition count test:
  - The run counter resets to 1 whenever the raw bit differs from the previous raw bit, and increments when it is equal.
  - The counter reaching RCT_CUTOFF flags a failure in that same cycle.
  - A constant input therefore enters FAIL at the edge after the RCT_CUTOFF-th sample.
- Von Neumann corrector (RUN only):
  - Raw bits are taken in non-overlapping pairs (first, second).
  - 01 emits 0; 10 emits 1; 00 and 11 emit nothing.
  - A pair straddling the WARMUP->RUN boundary is not formed; the first RUN sample always starts a new pair.
- Packer:
  - The k-th emitted bit of a word goes to bit k (LSB first).
  - When DATA_W bits are collected, the word is pushed to the FIFO in the same cycle and the bit count returns to 0.
- FIFO:
  - Registered. A word pushed at edge N is visible with out_valid=1 after edge N.
  - A pop occurs when out_valid & out_ready.
  - Push and pop in the same cycle: fullness is evaluated after the pop, so a push into a full FIFO with a simultaneous pop succeeds and the level is unchanged.
  - Push into a full FIFO with no pop: the word is dropped and overflow is set. overflow clears only on reset.
  - out_data holds the head word whenever out_valid=1 and is 0 when the FIFO is empty.
  - fifo_level is always exact.

Optional Feature:
- Macro TRNG_APT_EN.
- Defined: an adaptive proportion test also runs in WARMUP and RUN.
  - The first raw bit of each APT_WINDOW-bit window is the reference.
  - The count of raw bits equal to the reference, including the reference itself, exceeding APT_CUTOFF within the window is a health failure, with the same FAIL handling as the repetition count test.
  - The window restarts on entry to WARMUP.
- Undefined: no APT logic is present; only the repetition count test can cause FAIL.

Test Plan (WARMUP_BITS=4, RCT_CUTOFF=16, DATA_W=32, FIFO_DEPTH=4):
- enable=1, raw pattern 0,1,0,1,... -> after 4 warmup + 64 RUN cycles, out_valid=1 with out_data=0x00000000, fifo_level=1; health_fail stays 0.
- Raw pattern 1,0,1,0,... aligned to RUN start -> out_data=0xFFFFFFFF; with 00/11 pairs interleaved, word emission is delayed by 2 cycles per discarded pair and the value is unchanged.
- rand_in constant 8'h00 -> health_fail=1 at the edge after the 16th sample, out_valid=0; then fail_clear=1 with enable=1 -> WARMUP, health_fail=0.
- out_ready=0 with alternating raw input -> 4 words fill the FIFO (fifo_level=4); the 5th word is dropped and overflow=1; then out_ready=1 drains 4 words in 4 cycles.
- FIFO full, word completes in the same cycle as out_ready=1 pop -> no overflow, fifo_level stays 4.
- Drop enable to 0 mid-word (16 bits packed) and re-enable -> no partial word is emitted; the next word is 32 fresh bits after 4 warmup cycles. Assert reset mid-word in RUN -> all outputs 0 on the next cycle.
